baud_tx_ctrl: RTL
=================

// Module: baud_tx_ctrl
// PURPOSE
//  Sequences a serial transmit frame (start, data LSB-first, stop) on top of the
//  baud divider. Gates the divider via baud_ena only while a frame is in flight and
//  advances one bit per baud_tick. Sits between a byte producer (valid/ready) and
//  the tx pin; the divider instance sits beside it (clk_ena <= baud_ena, tick -> baud_tick).
// PARAMETERS
//  DATA_BITS  8  data bits per frame, legal 5..8
//  STOP_BITS  1  stop bits per frame, legal 1 or 2
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rstn       in   1          asynchronous reset, active low
//  tx_start   in   1          request: send tx_data (accepted only when tx_ready=1)
//  tx_data    in   DATA_BITS  byte to send, sampled on the accepting edge
//  tx_ready   out  1          1 = idle, able to accept tx_start
//  baud_ena   out  1          enable to baud divider, 1 for the whole frame
//  baud_tick  in   1          1-cycle pulse from divider marking end of a bit period
//  tx         out  1          serial line, idle high
//  tx_busy    out  1          1 while a frame is in flight (= ~tx_ready)
//  tx_done    out  1          1-cycle pulse when last stop bit period ends
// BEHAVIOUR
//  Clocking: one clock domain; reset asynchronous, active-low. All outputs registered.
//  Reset values: tx=1, tx_ready=1, tx_busy=0, baud_ena=0, tx_done=0, state=IDLE,
//   shift reg=0, bit counter=0. Reset asserted mid-frame aborts it immediately (tx=1).
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE : tx=1, baud_ena=0. tx_start=1 at edge k -> latch tx_data, goto START;
//          at k+1: tx=0, baud_ena=1, tx_ready=0, tx_busy=1.
//   START: on baud_tick -> DATA, tx=data[0], bit counter=0.
//   DATA : on baud_tick -> if counter==DATA_BITS-1 goto STOP, tx=1, stop counter=0;
//          else counter+1, tx=next bit (shift right, LSB first).
//   STOP : tx=1. On baud_tick -> if stop counter==STOP_BITS-1: goto IDLE, baud_ena=0,
//          tx_ready=1, tx_busy=0, tx_done=1 for exactly one cycle; else counter+1.
//  Frame length = 1+DATA_BITS+STOP_BITS baud_ticks; tx changes only on the edge
//   sampling baud_tick (or the accepting edge for the start bit).
//  Handshake: tx_start ignored while tx_ready=0 (no queuing, data not re-sampled).
//   tx_start in the cycle tx_done=1 (tx_ready=1) is accepted -> back-to-back frames,
//   baud_ena drops for exactly one cycle between frames (divider restarts phase).
//  baud_tick while baud_ena=0 (IDLE) is ignored. baud_tick held >1 cycle counts
//   once per cycle high (divider guarantees 1-cycle pulses; not filtered).
//  tx_data changes after acceptance have no effect on the frame in flight.
//  Counters sized $clog2(DATA_BITS) / 1 bit; no wrap beyond DATA_BITS-1.
// TESTING
//  1 Reset: rstn=0 any time -> tx=1, tx_ready=1, baud_ena=0, tx_done=0 same cycle.
//  2 Single byte 8N1, tick every 4 clks: tx_start with 8'hA5 -> tx sequence
//    0,1,0,1,0,0,1,0,1,1 each 4 clks; tx_done pulse once after 10th tick; baud_ena 40 clks.
//  3 Busy ignore: tx_start with 8'h3C mid-frame of 8'h55 -> only 8'h55 on tx, one tx_done.
//  4 Back-to-back: tx_start held high with 8'h01 then 8'hFF -> two full frames,
//    baud_ena low exactly 1 cycle between them, two tx_done pulses.
//  5 Reset mid-frame: rstn low during DATA bit 3 -> tx=1, idle; next tx_start 8'h81 sends clean frame.
//  6 STOP_BITS=2, DATA_BITS=7: tx_start 7'h7F -> 10 ticks total, tx high for last 2 ticks.

Source files
------------

// File: rtl/baud_tx_ctrl.sv
// Serial transmit frame sequencer: start bit, LSB-first data, stop bit(s).
// Gates an external baud divider and advances one bit per baud_tick.
module baud_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 baud_ena,
  input  logic                 baud_tick,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 tx_nxt, ena_nxt, ready_nxt, busy_nxt, done_nxt;

  assign state_dbg = state;

  // Handshake: a frame is accepted on any rising edge where tx_start=1 and
  // tx_ready=1; tx_data is captured on that same edge and never re-sampled.
  // tx_start while tx_ready=0 is dropped, not queued.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_q;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = tx;
    ena_nxt      = baud_ena;
    ready_nxt    = tx_ready;
    busy_nxt     = tx_busy;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_nxt = START;
          shift_nxt = tx_data;
          tx_nxt    = 1'b0;
          ena_nxt   = 1'b1;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_nxt   = DATA;
          tx_nxt      = shift_q[0];
          shift_nxt   = shift_q >> 1;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_DATA) begin
            state_nxt    = STOP;
            tx_nxt       = 1'b1;
            stop_cnt_nxt = 1'b0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            tx_nxt      = shift_q[0];
            shift_nxt   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (baud_tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_nxt = IDLE;
            ena_nxt   = 1'b0;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      baud_ena <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx       <= tx_nxt;
      baud_ena <= ena_nxt;
      tx_ready <= ready_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

endmodule
